// File: rtl/obj_ram_pkg.sv
// Shared defaults and address helper for the collision-object record store.
package obj_ram_pkg;

    localparam int unsigned DEF_DATA_W       = 32;
    localparam int unsigned DEF_RECORD_WORDS = 8;
    localparam int unsigned DEF_NUM_RECORDS  = 12;
    localparam int unsigned DEF_REC_LOG2     = $clog2(DEF_RECORD_WORDS);

    // Word address of the first word of a record; records are power-of-two sized, so a shift suffices.
    function automatic int unsigned rec_base(input int unsigned idx,
                                             input int unsigned log2_words = DEF_REC_LOG2);
        return idx << log2_words;
    endfunction

endpackage

// File: rtl/obj_record_ram_if.sv
// Host/datapath-facing bus of obj_record_ram: write stream, record reads and fill status.
interface obj_record_ram_if
    import obj_ram_pkg::*;
#(
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned RECORD_WORDS = DEF_RECORD_WORDS,
    parameter int unsigned NUM_RECORDS  = DEF_NUM_RECORDS,
    parameter int unsigned IDX_W        = $clog2(NUM_RECORDS)
);
    logic                           clr;
    logic                           wr_valid;
    logic                           wr_ready;
    logic [DATA_W-1:0]              wr_data;
    logic                           rd_req;
    logic [IDX_W-1:0]               rd_idx;
    logic                           rd_valid;
    logic [RECORD_WORDS*DATA_W-1:0] rd_data;
    logic                           rd_err;
    logic [IDX_W:0]                 count;
    logic                           full;
    logic                           empty;

    modport master (
        output clr, wr_valid, wr_data, rd_req, rd_idx,
        input  wr_ready, rd_valid, rd_data, rd_err, count, full, empty
    );

    modport slave (
        input  clr, wr_valid, wr_data, rd_req, rd_idx,
        output wr_ready, rd_valid, rd_data, rd_err, count, full, empty
    );

endinterface

// File: rtl/obj_ram_wr_ctrl.sv
// Write-side control: handshake, auto-incrementing word pointer, complete-record count, full/empty, clear.
module obj_ram_wr_ctrl
    import obj_ram_pkg::*;
#(
    parameter int unsigned RECORD_WORDS = DEF_RECORD_WORDS,
    parameter int unsigned NUM_RECORDS  = DEF_NUM_RECORDS,
    parameter int unsigned IDX_W        = $clog2(NUM_RECORDS),
    parameter int unsigned ADDR_W       = $clog2(NUM_RECORDS*RECORD_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              wr_en_c,
    output logic              wr_last_c,
    output logic [IDX_W:0]    count,
    output logic              full,
    output logic              empty
);
    localparam int unsigned LOG2_RW = $clog2(RECORD_WORDS);
    localparam int unsigned CNT_W   = IDX_W + 1;

    logic [ADDR_W-1:0] ptr_nxt;
    logic [CNT_W-1:0]  count_nxt;

    assign wr_ready  = !full;
    // A clear on the same edge drops the offered word.
    assign wr_en_c   = wr_valid && !full && !clr;
    assign wr_last_c = wr_en_c && (wr_ptr[LOG2_RW-1:0] == LOG2_RW'(RECORD_WORDS-1));

    always_comb begin
        ptr_nxt   = wr_ptr;
        count_nxt = count;
        if (clr) begin
            ptr_nxt   = '0;
            count_nxt = '0;
        end else if (wr_en_c) begin
            ptr_nxt = wr_ptr + ADDR_W'(1);
            if (wr_last_c) count_nxt = count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= ptr_nxt;
            count  <= count_nxt;
            full   <= (count_nxt == CNT_W'(NUM_RECORDS));
            empty  <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/obj_record_ram.sv
// Record store for collision-object parameters: word-wise fill, whole-record reads with 1-cycle latency.
// Optional OBJ_RAM_BYPASS_EN forwards the final word of a record being completed to a same-cycle read.
module obj_record_ram
    import obj_ram_pkg::*;
#(
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned RECORD_WORDS = DEF_RECORD_WORDS,
    parameter int unsigned NUM_RECORDS  = DEF_NUM_RECORDS,
    parameter int unsigned IDX_W        = $clog2(NUM_RECORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    obj_record_ram_if.slave  bus
);
    localparam int unsigned LOG2_RW = $clog2(RECORD_WORDS);
    localparam int unsigned DEPTH   = NUM_RECORDS * RECORD_WORDS;
    localparam int unsigned ADDR_W  = $clog2(DEPTH);
    localparam int unsigned REC_W   = RECORD_WORDS * DATA_W;
    localparam int unsigned CNT_W   = IDX_W + 1;

    if ((RECORD_WORDS < 2) || ((RECORD_WORDS & (RECORD_WORDS - 1)) != 0)) begin : g_bad_rw
        $error("obj_record_ram: RECORD_WORDS must be a power of two and at least 2");
    end

    logic [ADDR_W-1:0] wr_ptr;
    logic              wr_en_c;
    logic              wr_last_c;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [REC_W-1:0]  rec_c;
    logic              ok_c;
    logic              rd_valid;
    logic              rd_err;
    logic [REC_W-1:0]  rd_data;

    obj_ram_wr_ctrl #(
        .RECORD_WORDS (RECORD_WORDS),
        .NUM_RECORDS  (NUM_RECORDS),
        .IDX_W        (IDX_W),
        .ADDR_W       (ADDR_W)
    ) u_wr_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (bus.clr),
        .wr_valid  (bus.wr_valid),
        .wr_ready  (bus.wr_ready),
        .wr_ptr    (wr_ptr),
        .wr_en_c   (wr_en_c),
        .wr_last_c (wr_last_c),
        .count     (bus.count),
        .full      (bus.full),
        .empty     (bus.empty)
    );

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) mem[wr_ptr] <= bus.wr_data;
    end

    // Gather the addressed record; word k sits at {rd_idx, k}.
    always_comb begin
        rec_c = '0;
        ok_c  = (CNT_W'(bus.rd_idx) < bus.count);
        for (int unsigned k = 0; k < RECORD_WORDS; k++) begin
            rec_c[k*DATA_W +: DATA_W] = mem[ADDR_W'(rec_base(32'(bus.rd_idx), LOG2_RW) | k)];
        end
`ifdef OBJ_RAM_BYPASS_EN
        if (wr_last_c && (CNT_W'(bus.rd_idx) == bus.count)) begin
            ok_c = 1'b1;
            rec_c[(RECORD_WORDS-1)*DATA_W +: DATA_W] = bus.wr_data;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= bus.rd_req;
            if (bus.rd_req) begin
                rd_err  <= !ok_c;
                rd_data <= ok_c ? rec_c : '0;
            end
        end
    end

    assign bus.rd_valid = rd_valid;
    assign bus.rd_err   = rd_err;
    assign bus.rd_data  = rd_data;

endmodule

// File: doc/obj_record_ram.md
Name: obj_record_ram

Overview:
- Parametrised record store for collision-detection object data.
- Write side: fills the memory one word per cycle, with a valid/ready handshake and an auto-incrementing pointer.
- Read side: returns a whole record (RECORD_WORDS words) per request, with a valid strobe and an error flag.
- Sits between the host/loader that streams float32 object parameters and the collision datapath that consumes complete records.

Parameters:
- DATA_W, 32: word width in bits (IEEE-754 single).
- RECORD_WORDS, 8: words per record. Must be a power of two and ≥2; elaboration fails otherwise.
- NUM_RECORDS, 12: record capacity. Memory depth = NUM_RECORDS*RECORD_WORDS.
- IDX_W, $clog2(NUM_RECORDS): record index width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear of write pointer and record count.
- wr_valid  in  1  write word offered.
- wr_ready  out  1  store can accept a word.
- wr_data  in  DATA_W  word to write.
- rd_req  in  1  record read request (single-cycle pulse or level).
- rd_idx  in  IDX_W  record index to read.
- rd_valid  out  1  read response strobe.
- rd_data  out  RECORD_WORDS*DATA_W  record; word k at bits [k*DATA_W +: DATA_W].
- rd_err  out  1  qualifies rd_valid: requested record not complete.
- count  out  IDX_W+1  number of complete records.
- full  out  1  count == NUM_RECORDS.
- empty  out  1  count == 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr=0, count=0, full=0, empty=1.
  - rd_valid=0, rd_err=0, rd_data=0.
  - wr_ready=1 once rst_n is released.
  - Memory contents are not reset and are undefined until written.
- wr_ready = !full (combinational).
- Write accept = wr_valid && wr_ready:
  - mem[wr_ptr] <= wr_data; wr_ptr++.
  - When the accepted word is the last of a record (wr_ptr[log2 RECORD_WORDS-1:0] == RECORD_WORDS-1), count++ on the same edge.
  - full and empty are registered from the next count value.
- wr_valid while full: ignored, no pointer change, no error.
- clr: wr_ptr=0, count=0 next edge. It takes priority over a simultaneous write accept, and that word is dropped. A partially written record is discarded. Memory is untouched.
- Read, 1-cycle latency. rd_req sampled at edge N; at edge N+1:
  - rd_valid=1 for exactly one cycle per sampled request.
  - If rd_idx < count (count as of edge N): rd_data = mem[rd_idx*RECORD_WORDS + k] for k=0..RECORD_WORDS-1, rd_err=0.
  - Otherwise: rd_data=0, rd_err=1.
  - Back-to-back requests are accepted every cycle.
  - rd_data holds its last value while rd_valid=0.
- Read and write in the same cycle (different records): both proceed; there are no stalls.
- clr and rd_req in the same cycle: the read uses the pre-clear count.
- Address arithmetic uses shift/concatenation {rd_idx, k}; no multiplier.
- Reset asserted mid-burst: all state returns to reset values immediately; a pending rd_valid is cancelled.

Optional Feature:
- OBJ_RAM_BYPASS_EN, defined:
  - Write-to-read forwarding. A read of rd_idx == count in the cycle the final word of that record is accepted returns the complete record.
  - The last word comes from wr_data; the other words come from memory. rd_err=0.
- OBJ_RAM_BYPASS_EN, undefined:
  - The same read returns rd_err=1, rd_data=0.
  - Synthesis infers plain block RAM with no forwarding mux.

Decomposition:
- Package obj_ram_pkg holds:
  - default DATA_W, RECORD_WORDS, NUM_RECORDS;
  - a function for record base address;
  - localparam for log2(RECORD_WORDS).
- One sub-module, obj_ram_wr_ctrl, owns the handshake, wr_ptr, count, full/empty and clr.
- The top owns the memory array, read mux/registers and the bypass.

Test Plan:
- Reset then write 8 words 0x3f000000..+7 → count=1 after 8th accept, empty=0. Read idx 0 next cycle → rd_valid=1 one cycle later, rd_data word k = 0x3f000000+k, rd_err=0.
- Fill 96 words → full=1, wr_ready=0 after the 96th accept. 97th wr_valid ignored (count stays 12). Read idx 11 → last 8 words returned.
- Write 5 words, read idx 0 → rd_err=1, rd_data=0. Assert clr, then write 8 words → count=1 and record 0 holds the new data.
- Final word of record 2 accepted in the same cycle as rd_req idx 2 → with macro: rd_err=0 and word 7 = that wr_data; without macro: rd_err=1.
- rd_req held high 4 cycles over idx 0,1,0,1 with 2 records stored → 4 consecutive rd_valid pulses, correct data each.
- Assert rst_n low between rd_req and response → no rd_valid, count=0, wr_ready=1 after release.
